// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: two-flop synchroniser, mid-cell sampling, stop-bit check,
// and a one-entry valid/ready holding register with framing-error and overrun flags.
module uart_rx_deframer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       in_UART_Clock,
  input  logic       in_UART_Reset_n,
  input  logic       in_Rx_Serial,
  input  logic       in_Rx_Ready,
  output logic [7:0] out_Rx_8bitData,
  output logic       out_Rx_Valid,
  output logic       out_Rx_Busy,
  output logic       out_Rx_Frame_Err,
  output logic       out_Rx_Overrun
);

  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q;
  logic        valid_q, ferr_q, ovr_q;
  logic        rx_s;
  logic        deliver, ferr_set, accept;

  assign rx_s = sync_q[1];

  // State register and bit-cell datapath.
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // see pre-edge values and the order of statements cannot change behaviour.
  always_ff @(posedge in_UART_Clock or negedge in_UART_Reset_n) begin
    if (!in_UART_Reset_n) begin
      sync_q  <= 2'b00;
      state_q <= WAIT_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      sync_q  <= {sync_q[0], in_Rx_Serial};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and datapath logic.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      WAIT_IDLE: begin
        cnt_d = 8'd0;
        idx_d = 3'd0;
        if (rx_s) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = 8'd0;
        idx_d = 3'd0;
        // The cycle that first shows the low level is start-cell position 0.
        if (!rx_s) begin
          if (CLKS_PER_BIT == 1) begin
            state_d = DATA;
          end else begin
            state_d = START;
            cnt_d   = 8'd1;
          end
        end
      end
      START: begin
        if (cnt_q == HALF && rx_s) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == LAST) begin
          state_d = DATA;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (cnt_q == HALF) shift_d = {rx_s, shift_q[7:1]};
        if (cnt_q == LAST) begin
          cnt_d = 8'd0;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a start bit with no idle gap is still caught.
        if (cnt_q == HALF) begin
          cnt_d   = 8'd0;
          state_d = rx_s ? IDLE : WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = WAIT_IDLE;
        cnt_d   = 8'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    out_Rx_Busy = (state_q != IDLE);
    deliver     = (state_q == STOP) && (cnt_q == HALF) && rx_s;
    ferr_set    = (state_q == STOP) && (cnt_q == HALF) && !rx_s;
  end

  assign accept = valid_q && in_Rx_Ready;

  // Holding register; an acceptance in the delivery cycle frees the slot.
  always_ff @(posedge in_UART_Clock or negedge in_UART_Reset_n) begin
    if (!in_UART_Reset_n) begin
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr_set;
      if (deliver) begin
        if (!valid_q || in_Rx_Ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
          if (accept) ovr_q <= 1'b0;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (accept) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign out_Rx_8bitData  = data_q;
  assign out_Rx_Valid     = valid_q;
  assign out_Rx_Frame_Err = ferr_q;
  assign out_Rx_Overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: one instance at 1 clock/bit, one at 16.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx1, rdy1, rx16, rdy16;
  logic [7:0] d1, d16;
  logic       v1, b1, fe1, ov1;
  logic       v16, b16, fe16, ov16;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         ferr16_n = 0;
  int         ferr16_t = 0;
  int         ferr1_n  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_deframer #(.CLKS_PER_BIT(1)) u_dut1 (
    .in_UART_Clock   (clk),
    .in_UART_Reset_n (rst_n),
    .in_Rx_Serial    (rx1),
    .in_Rx_Ready     (rdy1),
    .out_Rx_8bitData (d1),
    .out_Rx_Valid    (v1),
    .out_Rx_Busy     (b1),
    .out_Rx_Frame_Err(fe1),
    .out_Rx_Overrun  (ov1)
  );

  uart_rx_deframer #(.CLKS_PER_BIT(16)) u_dut16 (
    .in_UART_Clock   (clk),
    .in_UART_Reset_n (rst_n),
    .in_Rx_Serial    (rx16),
    .in_Rx_Ready     (rdy16),
    .out_Rx_8bitData (d16),
    .out_Rx_Valid    (v16),
    .out_Rx_Busy     (b16),
    .out_Rx_Frame_Err(fe16),
    .out_Rx_Overrun  (ov16)
  );

  // Record accepted bytes and frame-error pulses of both instances.
  always @(negedge clk) begin
    if (v16 && rdy16) begin
      rx_q.push_back(d16);
      rx_t.push_back(cyc);
    end
    if (fe16) begin
      ferr16_n++;
      ferr16_t = cyc;
    end
    if (fe1) ferr1_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int cpb, input logic v);
    if (cpb == 1) rx1 = v;
    else          rx16 = v;
  endtask

  // Drive one 8N1 frame; t0 is the cycle the start bit first appears.
  task automatic send(input int cpb, input logic [7:0] b, input logic stop_v, output int t0);
    drive(cpb, 1'b0);
    t0 = cyc;
    repeat (cpb) tick();
    for (int i = 0; i < 8; i++) begin
      drive(cpb, b[i]);
      repeat (cpb) tick();
    end
    drive(cpb, stop_v);
    repeat (cpb) tick();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("rx_timeout", 32'(rx_q.size() >= n), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, m, fe_before;
    logic [7:0] brk;

    rst_n = 1'b0; rx1 = 1'b1; rx16 = 1'b1; rdy1 = 1'b0; rdy16 = 1'b0;
    repeat (3) tick();
    check("rst_data",  32'(d16),  32'h0);
    check("rst_valid", 32'(v16),  32'h0);
    check("rst_busy",  32'(b16),  32'h1);
    check("rst_ferr",  32'(fe16), 32'h0);
    check("rst_ovr",   32'(ov16), 32'h0);

    rst_n = 1'b1;
    tick(); tick();
    check("rel_busy_e2", 32'(b16), 32'h1);
    tick();
    check("rel_busy_e3",  32'(b16), 32'h0);
    check("rel_busy1_e3", 32'(b1),  32'h0);

    // 1 clock/bit, 0xA5: valid for one cycle at T+12.
    rdy1 = 1'b1;
    send(1, 8'hA5, 1'b1, t0);
    tick(); tick();
    check("c1_cycle", 32'(cyc - t0), 32'd12);
    check("c1_valid", 32'(v1), 32'h1);
    check("c1_data",  32'(d1), 32'hA5);
    tick();
    check("c1_valid_drop", 32'(v1), 32'h0);
    check("c1_ferr", 32'(ferr1_n), 32'd0);
    check("c1_ovr",  32'(ov1), 32'h0);

    // 16 clocks/bit, three back-to-back frames.
    rdy16 = 1'b1;
    rx_q.delete(); rx_t.delete();
    send(16, 8'h00, 1'b1, t0);
    send(16, 8'hFF, 1'b1, t1);
    send(16, 8'h3C, 1'b1, t2);
    wait_rx(3, 400);
    if (rx_q.size() >= 3) begin
      check("b2b_d0", 32'(rx_q[0]), 32'h00);
      check("b2b_d1", 32'(rx_q[1]), 32'hFF);
      check("b2b_d2", 32'(rx_q[2]), 32'h3C);
      check("b2b_t0", 32'(rx_t[0] - t0), 32'd154);
      check("b2b_gap1", 32'(rx_t[1] - rx_t[0]), 32'd160);
      check("b2b_gap2", 32'(rx_t[2] - rx_t[1]), 32'd160);
    end
    check("b2b_ferr", 32'(ferr16_n), 32'd0);

    // Five-cycle glitch: false start abandoned at mid start-cell.
    repeat (10) tick();
    rx_q.delete(); rx_t.delete();
    rx16 = 1'b0;
    m = cyc;
    repeat (5) tick();
    rx16 = 1'b1;
    check("glitch_busy_mid", 32'(b16), 32'h1);
    repeat (5) tick();
    check("glitch_cycle", 32'(cyc - m), 32'd10);
    check("glitch_busy_end", 32'(b16), 32'h0);
    repeat (20) tick();
    check("glitch_norx",  32'(rx_q.size()), 32'd0);
    check("glitch_valid", 32'(v16), 32'h0);
    check("glitch_ferr",  32'(ferr16_n), 32'd0);

    // Zero stop bit and a 40-cycle break.
    send(16, 8'h55, 1'b0, t0);
    repeat (24) tick();
    check("brk_ferr_n", 32'(ferr16_n), 32'd1);
    check("brk_ferr_t", 32'(ferr16_t - t0), 32'd154);
    check("brk_busy_low", 32'(b16), 32'h1);
    check("brk_norx", 32'(rx_q.size()), 32'd0);
    rx16 = 1'b1;
    m = cyc;
    tick(); tick();
    check("brk_busy_m2", 32'(b16), 32'h1);
    tick();
    check("brk_busy_m3", 32'(b16), 32'h0);
    repeat (5) tick();
    send(16, 8'h81, 1'b1, t0);
    wait_rx(1, 400);
    if (rx_q.size() >= 1) check("brk_next", 32'(rx_q[0]), 32'h81);
    check("brk_ferr_once", 32'(ferr16_n), 32'd1);

    // Overrun: consumer stalled across two frames.
    repeat (10) tick();
    rdy16 = 1'b0;
    rx_q.delete(); rx_t.delete();
    send(16, 8'h11, 1'b1, t0);
    send(16, 8'h22, 1'b1, t1);
    repeat (20) tick();
    check("ovr_valid", 32'(v16),  32'h1);
    check("ovr_data",  32'(d16),  32'h11);
    check("ovr_flag",  32'(ov16), 32'h1);
    rdy16 = 1'b1;
    tick();
    rdy16 = 1'b0;
    check("ovr_acc_valid", 32'(v16),  32'h0);
    check("ovr_acc_flag",  32'(ov16), 32'h0);
    check("ovr_acc_data",  32'(d16),  32'h11);
    check("ovr_acc_n",     32'(rx_q.size()), 32'd1);

    // Reset during data bit 4, then a clean 0x7E.
    rdy16 = 1'b1;
    repeat (5) tick();
    rx_q.delete(); rx_t.delete();
    fe_before = ferr16_n;
    brk = 8'hC3;
    rx16 = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 4; i++) begin
      rx16 = brk[i];
      repeat (16) tick();
    end
    rx16 = brk[4];
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy",  32'(b16),  32'h1);
    check("mrst_valid", 32'(v16),  32'h0);
    check("mrst_data",  32'(d16),  32'h0);
    check("mrst_ovr",   32'(ov16), 32'h0);
    check("mrst_ferr",  32'(fe16), 32'h0);
    check("mrst_data1", 32'(d1),   32'h0);
    rx16 = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (200) tick();
    check("mrst_norx",   32'(rx_q.size()), 32'd0);
    check("mrst_noval",  32'(v16), 32'h0);
    check("mrst_noferr", 32'(ferr16_n - fe_before), 32'd0);
    send(16, 8'h7E, 1'b1, t0);
    wait_rx(1, 400);
    if (rx_q.size() >= 1) begin
      check("mrst_7e",   32'(rx_q[0]), 32'h7E);
      check("mrst_7e_t", 32'(rx_t[0] - t0), 32'd154);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
